// File: rtl/adder_pkg.sv
// Shared types and segment geometry for the pipelined ripple-carry adder.
// Segment k covers bits [seg_lo(k), seg_lo(k+1)).
package adder_pkg;

    localparam int MAX_WIDTH = 64;

    typedef struct packed {
        logic                 valid;
        logic                 carry;
        logic [MAX_WIDTH-1:0] sum;
        logic [MAX_WIDTH-1:0] a;
        logic [MAX_WIDTH-1:0] b;
    } stage_t;

    function automatic int seg_width(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

    function automatic int seg_lo(input int k, input int width,
                                  input int stages);
        int lo;
        lo = k * seg_width(width, stages);
        return (lo > width) ? width : lo;
    endfunction

endpackage

// File: rtl/rca_segment.sv
// Combinational ripple-carry segment: W full adders in a chain.
module rca_segment #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] c;

    always_comb begin
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[W];

endmodule

// File: rtl/pipelined_rca_adder.sv
// Pipelined add/subtract built from STAGES registered ripple segments.
// Define ADDER_OVF_EN to add the o_overflow signed-overflow output.
module pipelined_rca_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add_term1,
    input  logic [WIDTH-1:0] i_add_term2,
    input  logic             i_carry_in,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH:0]   o_result
`ifdef ADDER_OVF_EN
    ,
    output logic             o_overflow
`endif
);

    stage_t            in_pl;
    stage_t            last_q;
    stage_t            last_nxt;
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] en;

    // Subtract is A + ~B + 1, so the carry-in is forced high.
    always_comb begin
        in_pl              = '0;
        in_pl.valid        = i_valid;
        in_pl.carry        = i_sub | i_carry_in;
        in_pl.a[WIDTH-1:0] = i_add_term1;
        in_pl.b[WIDTH-1:0] = i_sub ? ~i_add_term2 : i_add_term2;
    end

    always_comb begin
        en[STAGES-1] = !vld[STAGES-1] || i_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            en[k] = !vld[k] || en[k+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = seg_lo(k, WIDTH, STAGES);
        localparam int HI = seg_lo(k + 1, WIDTH, STAGES);

        stage_t src;
        stage_t nxt;
        stage_t q;

        if (k == 0) begin : g_first
            assign src = in_pl;
        end else begin : g_chain
            assign src = g_stage[k-1].q;
        end

        // Narrow configurations can leave trailing stages with no bits.
        if (HI > LO) begin : g_seg
            logic [HI-LO-1:0] s;
            logic             co;

            rca_segment #(.W(HI - LO)) u_seg (
                .a   (src.a[LO +: HI-LO]),
                .b   (src.b[LO +: HI-LO]),
                .cin (src.carry),
                .sum (s),
                .cout(co)
            );

            always_comb begin
                nxt                  = src;
                nxt.sum[LO +: HI-LO] = s;
                nxt.carry            = co;
            end
        end else begin : g_pass
            assign nxt = src;
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                q <= '0;
            end else if (en[k]) begin
                q <= nxt;
            end
        end

        assign vld[k] = q.valid;

        if (k == STAGES - 1) begin : g_last
            assign last_q   = q;
            assign last_nxt = nxt;
        end
    end

    assign o_ready  = en[0];
    assign o_valid  = last_q.valid;
    assign o_result = {last_q.carry, last_q.sum[WIDTH-1:0]};

`ifdef ADDER_OVF_EN
    logic ovf_q;
    logic c_msb;

    assign c_msb = last_nxt.a[WIDTH-1] ^ last_nxt.b[WIDTH-1]
                 ^ last_nxt.sum[WIDTH-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ovf_q <= 1'b0;
        end else if (en[STAGES-1]) begin
            ovf_q <= c_msb ^ last_nxt.carry;
        end
    end

    assign o_overflow = ovf_q;
`else
    logic unused_last;
    assign unused_last = ^last_nxt;
`endif

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Directed self-checking bench for pipelined_rca_adder (WIDTH=32, STAGES=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_pipelined_rca_adder;

    localparam int W = 32;
    localparam int S = 4;

    logic         clk        = 1'b0;
    logic         rst_n      = 1'b0;
    logic         i_valid    = 1'b0;
    logic         i_carry_in = 1'b0;
    logic         i_sub      = 1'b0;
    logic         i_ready    = 1'b1;
    logic [W-1:0] a          = '0;
    logic [W-1:0] b          = '0;
    logic         o_ready;
    logic         o_valid;
    logic [W:0]   o_result;
`ifdef ADDER_OVF_EN
    logic         o_overflow;
`endif

    int checks = 0;
    int errors = 0;

    // Hand-computed streaming vectors.
    logic [W-1:0] ta [8] = '{32'h1, 32'hFFFFFFFF, 32'hA, 32'h0,
                             32'h0000FFFF, 32'hFFFF0000,
                             32'h00FF00FF, 32'h3};
    logic [W-1:0] tb [8] = '{32'h1, 32'hFFFFFFFF, 32'h3, 32'h0,
                             32'h00000001, 32'h00010000,
                             32'h0F0F0F0F, 32'h3};
    logic         tc [8] = '{1'b0, 1'b0, 1'b0, 1'b1,
                             1'b0, 1'b0, 1'b0, 1'b0};
    logic         ts [8] = '{1'b0, 1'b0, 1'b1, 1'b0,
                             1'b0, 1'b0, 1'b0, 1'b1};
    logic [W:0]   te [8] = '{33'h0_00000002, 33'h1_FFFFFFFE,
                             33'h1_00000007, 33'h0_00000001,
                             33'h0_00010000, 33'h1_00000000,
                             33'h0_100E100E, 33'h1_00000000};

    always #5 clk = ~clk;

    pipelined_rca_adder #(.WIDTH(W), .STAGES(S)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_add_term1(a),
        .i_add_term2(b),
        .i_carry_in (i_carry_in),
        .i_sub      (i_sub),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_result   (o_result)
`ifdef ADDER_OVF_EN
        ,
        .o_overflow (o_overflow)
`endif
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Drives one operation and waits (bounded) for its result.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ci, input logic su,
                         output logic [W:0] res, output int lat);
        @(negedge clk);
        a          = x;
        b          = y;
        i_carry_in = ci;
        i_sub      = su;
        i_valid    = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        lat     = 1;
        while (o_valid !== 1'b1 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        res = o_result;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (o_valid !== 1'b0 || o_result !== '0) begin
            errors++;
            $display("FAIL reset_state: valid=%b result=%h required 0/0",
                     o_valid, o_result);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: ready=%b required 1", o_ready);
        end
    endtask

    task automatic test_carry_chain();
        logic [W:0] r;
        int         lat;
        do_op(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, r, lat);
        checks++;
        if (lat != S || r !== 33'h1_00000000) begin
            errors++;
            $display("FAIL carry_all: lat=%0d result=%h required %0d/%h",
                     lat, r, S, 33'h1_00000000);
        end
        do_op(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, r, lat);
        checks++;
        if (r !== 33'h0_ACF13568) begin
            errors++;
            $display("FAIL add_mix: result=%h required %h",
                     r, 33'h0_ACF13568);
        end
        do_op(32'h80000000, 32'h80000000, 1'b0, 1'b0, r, lat);
        checks++;
        if (r !== 33'h1_00000000) begin
            errors++;
            $display("FAIL add_msb: result=%h required %h",
                     r, 33'h1_00000000);
        end
        do_op(32'h1, 32'h2, 1'b1, 1'b0, r, lat);
        checks++;
        if (r !== 33'h0_00000004) begin
            errors++;
            $display("FAIL add_cin: result=%h required %h",
                     r, 33'h0_00000004);
        end
    endtask

    task automatic test_subtract();
        logic [W:0] r;
        int         lat;
        do_op(32'h5, 32'h7, 1'b0, 1'b1, r, lat);
        checks++;
        if (r !== 33'h0_FFFFFFFE) begin
            errors++;
            $display("FAIL sub_borrow: result=%h required %h",
                     r, 33'h0_FFFFFFFE);
        end
        do_op(32'h7, 32'h5, 1'b0, 1'b1, r, lat);
        checks++;
        if (r !== 33'h1_00000002) begin
            errors++;
            $display("FAIL sub_noborrow: result=%h required %h",
                     r, 33'h1_00000002);
        end
        do_op(32'h7, 32'h5, 1'b1, 1'b1, r, lat);
        checks++;
        if (r !== 33'h1_00000002) begin
            errors++;
            $display("FAIL sub_cin_ignored: result=%h required %h",
                     r, 33'h1_00000002);
        end
        do_op(32'h0, 32'h0, 1'b0, 1'b1, r, lat);
        checks++;
        if (r !== 33'h1_00000000) begin
            errors++;
            $display("FAIL sub_zero: result=%h required %h",
                     r, 33'h1_00000000);
        end
    endtask

    task automatic test_back_to_back();
        i_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            checks++;
            if (c >= S && c < S + 8) begin
                if (o_valid !== 1'b1 || o_result !== te[c-S]) begin
                    errors++;
                    $display("FAIL stream[%0d]: valid=%b result=%h required 1/%h",
                             c - S, o_valid, o_result, te[c-S]);
                end
            end else if (o_valid !== 1'b0) begin
                errors++;
                $display("FAIL stream_idle@%0d: valid=%b required 0",
                         c, o_valid);
            end
            if (c < 8) begin
                checks++;
                if (o_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_ready@%0d: ready=%b required 1",
                             c, o_ready);
                end
                a          = ta[c];
                b          = tb[c];
                i_carry_in = tc[c];
                i_sub      = ts[c];
                i_valid    = 1'b1;
            end else begin
                i_valid = 1'b0;
            end
        end
    endtask

    task automatic test_backpressure();
        i_ready = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c >= 4 && c <= 7) begin
                checks++;
                if (o_valid !== 1'b1 || o_result !== te[0] || o_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall@%0d: valid=%b result=%h ready=%b required 1/%h/0",
                             c, o_valid, o_result, o_ready, te[0]);
                end
            end else if (c >= 8 && c <= 10) begin
                checks++;
                if (o_valid !== 1'b1 || o_result !== te[c-7]) begin
                    errors++;
                    $display("FAIL drain[%0d]: valid=%b result=%h required 1/%h",
                             c - 7, o_valid, o_result, te[c-7]);
                end
            end else if (c == 11) begin
                checks++;
                if (o_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL drain_extra: valid=%b result=%h required 0",
                             o_valid, o_result);
                end
            end
            if (c < 4) begin
                a          = ta[c];
                b          = tb[c];
                i_carry_in = tc[c];
                i_sub      = ts[c];
                i_valid    = 1'b1;
            end else if (c < 7) begin
                a          = 32'hDEADBEEF;
                b          = 32'h11111111;
                i_carry_in = 1'b0;
                i_sub      = 1'b0;
                i_valid    = 1'b1;
            end else begin
                i_valid = 1'b0;
                i_ready = 1'b1;
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [W:0] r;
        int         lat;
        i_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c < 3) begin
                a          = ta[c];
                b          = tb[c];
                i_carry_in = tc[c];
                i_sub      = ts[c];
                i_valid    = 1'b1;
            end else begin
                i_valid = 1'b0;
            end
        end
        checks++;
        if (o_valid !== 1'b1) begin
            errors++;
            $display("FAIL midflight_pre: valid=%b required 1", o_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_result !== '0) begin
            errors++;
            $display("FAIL midflight_async: valid=%b result=%h required 0/0",
                     o_valid, o_result);
        end
        #1 rst_n = 1'b1;
        i_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
                errors++;
                $display("FAIL midflight_stale@%0d: valid=%b ready=%b required 0/1",
                         c, o_valid, o_ready);
            end
        end
        do_op(32'h00000100, 32'h00000023, 1'b0, 1'b0, r, lat);
        checks++;
        if (lat != S || r !== 33'h0_00000123) begin
            errors++;
            $display("FAIL midflight_new: lat=%0d result=%h required %0d/%h",
                     lat, r, S, 33'h0_00000123);
        end
    endtask

`ifdef ADDER_OVF_EN
    task automatic test_overflow();
        logic [W:0] r;
        int         lat;
        do_op(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, r, lat);
        checks++;
        if (o_overflow !== 1'b1 || r !== 33'h0_80000000) begin
            errors++;
            $display("FAIL ovf_set: ovf=%b result=%h required 1/%h",
                     o_overflow, r, 33'h0_80000000);
        end
        do_op(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, r, lat);
        checks++;
        if (o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b required 0", o_overflow);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_carry_chain();
        test_subtract();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
`ifdef ADDER_OVF_EN
        test_overflow();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_rca_adder.md
Name: pipelined_rca_adder

Overview:
Parametrised, pipelined successor to the fixed-width combinational ripple-carry adder. Splits a WIDTH-bit add/subtract into STAGES ripple-carry segments, with one register stage per segment. Carries are passed between stages in registers. Valid/ready handshakes on both sides give a throughput of one operation per cycle. It sits in the datapath wherever a wide adder must meet timing, and it stalls cleanly under downstream backpressure.

Parameters:
WIDTH, 32, operand width in bits; legal range 2..64.
STAGES, 4, number of pipeline segments; legal range 1..WIDTH. Segment width = ceil(WIDTH/STAGES); the last segment takes the remainder.

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_valid  input  1  input operands valid
o_ready  output  1  adder can accept operands this cycle
i_add_term1  input  WIDTH  operand A
i_add_term2  input  WIDTH  operand B
i_carry_in  input  1  carry in; ignored when i_sub=1
i_sub  input  1  0: A+B+cin; 1: A-B
o_valid  output  1  o_result valid
i_ready  input  1  downstream accepts o_result
o_result  output  WIDTH+1  sum; MSB = carry out (in subtract mode, MSB=1 means no borrow)

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous, active-low.
- Reset values: all stage valid flags = 0; o_valid = 0; o_result = 0; o_ready = 1 once reset is released.
- Subtract mode: B_eff = ~B and effective cin = 1. Add mode: B_eff = B and cin = i_carry_in.
- Stage k (k = 0..STAGES-1):
  - Adds segment k of A and B_eff, using the carry registered by stage k-1 (stage 0 uses the effective cin).
  - Registers the segment sum, the carry out, the remaining upper operand segments and the already-computed lower sum bits.
- Latency: exactly STAGES cycles from input acceptance (i_valid && o_ready) to o_valid, assuming no stall.
- Flow control: each stage has a valid flag and advances when its successor is empty or advancing.
  - The last stage advances when !o_valid || i_ready.
  - o_ready = !v0 || stage0_advances. This is combinational from i_ready through the chain; there is no skid buffer.
- Full pipeline with i_ready=1 sustains 1 op/cycle. With i_ready=0 and every stage full, o_ready=0.
- Stability: while o_valid && !i_ready, o_result and o_valid hold stable. Inputs not accepted (o_ready=0) are not captured.
- Ordering: results leave in acceptance order; no loss, no duplication.
- Carry out: MSB of o_result = final carry out of stage STAGES-1.
- STAGES=1: a single registered ripple adder with latency 1.
- Reset mid-operation: all in-flight operations are discarded and o_valid falls immediately (asynchronously). No stale result emerges after release.
- Arithmetic is unsigned modulo 2^(WIDTH+1) in the o_result representation.

Optional Feature:
ADDER_OVF_EN
- Defined: adds output port o_overflow (1 bit), valid with o_valid. It flags two's-complement signed overflow: the carry into the MSB XOR the carry out of the MSB, computed in the last stage. It is reset to 0 and held stable under a stall.
- Undefined: the port and its logic are absent.

Decomposition:
- Package adder_pkg holds:
  - the function seg_width(WIDTH, STAGES);
  - the function seg_lo(k) for segment bit offsets;
  - the localparam MAX_WIDTH=64;
  - a typedef for the per-stage payload struct (valid, carry, partial sum, pending operand bits).
- Sub-module rca_segment: combinational full-adder chain with parameter W and ports a, b, cin, sum, cout. It is instantiated STAGES times via generate.

Test Plan:
- Carry across all segments (WIDTH=32, STAGES=4): A=0xFFFFFFFF, B=0x00000001, cin=0, add → after 4 cycles o_valid=1, o_result=0x1_00000000.
- Subtract with borrow: A=5, B=7, i_sub=1 → o_result=0x0_FFFFFFFE (MSB 0 = borrow). A=7, B=5 → 0x1_00000002.
- Streaming: 8 back-to-back random ops with i_ready=1 → o_valid high for 8 consecutive cycles starting at cycle 4, results match the reference model in order.
- Backpressure: pipeline full, i_ready=0 for 3 cycles:
  - o_ready=0 and o_result is held unchanged;
  - on i_ready=1, all results drain in order with no drop or duplicate.
- Reset mid-flight: 3 ops in flight, pulse i_rst_n low between clock edges:
  - o_valid=0 immediately;
  - after release, no output until new input and o_ready=1.
- With ADDER_OVF_EN: A=0x7FFFFFFF, B=1 → o_overflow=1, o_result=0x0_80000000. A=0xFFFFFFFF, B=1 → o_overflow=0.
